store_monitor: RTL

- Synthesizable store-trace and verdict block downstream of the MIPS core `top`.
- Consumes the core's data-memory write port (memwrite, dataadr, writedata) and pc.
- Records each store in a show-ahead trace FIFO and drives sticky pass/fail/done flags, so self-checking runs on the bench and on the FPGA board.
- Runs on the same divided clock as the core (clk_run in the system).

---
 rtl/store_monitor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - store trace FIFO and sticky pass/fail verdict for the core's data-memory write port
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   memwrite, dataadr,
//   writedata, pc               core store strobe, address, data and pc of the store
//   rd_en                       pop the trace head
//   rd_valid, rd_addr,
//   rd_data, rd_pc              show-ahead head entry; all zero when the trace is empty
//   count                       trace occupancy
//   overflow                    sticky: a store was dropped on a full trace
//   store_cnt                   stores seen while running, saturating
//   done, pass, fail            sticky verdict flags
module store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [15:0] TIMEOUT   = 16'd500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic [31:0]              pc,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [31:0]              rd_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              store_cnt,
  output logic                     done,
  output logic                     pass,
  output logic                     fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   tmo_cnt;

  logic in_run;
  logic push_req;
  logic pop;
  logic full;
  logic push_do;
  logic drop;

  assign in_run   = (state == ST_RUN);
  assign push_req = in_run && memwrite;
  assign pop      = rd_en && (count != '0);
  assign full     = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full trace still accepts the store.
  assign push_do  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign rd_valid = (count != '0);
  assign rd_addr  = rd_valid ? mem_addr[rd_ptr] : 32'd0;
  assign rd_data  = rd_valid ? mem_data[rd_ptr] : 32'd0;
  assign rd_pc    = rd_valid ? mem_pc[rd_ptr]   : 32'd0;

  // A verdict store takes priority over the timeout, so a PASS store on the
  // last allowed cycle still passes.
  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      if (memwrite && (dataadr == PASS_ADDR)) begin
        state_nxt = (writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
      end else if (tmo_cnt == (TIMEOUT - 16'd1)) begin
        state_nxt = ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      store_cnt <= 16'd0;
      tmo_cnt   <= 16'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt != ST_RUN);
      pass  <= (state_nxt == ST_PASS);
      fail  <= (state_nxt == ST_FAIL);

      if (push_do) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);

      case ({push_do, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;

      if (push_req && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;

      if (in_run) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Trace storage needs no reset: rd_* are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && push_do) begin
      mem_addr[wr_ptr] <= dataadr;
      mem_data[wr_ptr] <= writedata;
      mem_pc[wr_ptr]   <= pc;
    end
  end

endmodule
